// File: rtl/servo_pkg.sv
// Shared types, default timing constants and the width clamp for the servo frame scheduler.
package servo_pkg;

   localparam int unsigned CLK_PER_US = 100;
   localparam int unsigned FRAME_US   = 20000;
   localparam int unsigned SLOT_US    = 2500;
   localparam int unsigned MIN_US     = 500;
   localparam int unsigned MAX_US     = 2500;
   localparam int unsigned DEF_US     = 1500;
   localparam int unsigned US_W       = 12;

   typedef logic [1:0] servo_state_t;
   localparam servo_state_t S_IDLE  = 2'd0;
   localparam servo_state_t S_LOAD  = 2'd1;
   localparam servo_state_t S_PULSE = 2'd2;
   localparam servo_state_t S_REST  = 2'd3;

   // Unsigned clamp of a commanded width into [lo, hi].
   function automatic logic [US_W-1:0] clamp_us(input logic [US_W-1:0] v,
                                                 input logic [US_W-1:0] lo,
                                                 input logic [US_W-1:0] hi);
      if (v < lo) begin
         return lo;
      end else if (v > hi) begin
         return hi;
      end else begin
         return v;
      end
   endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Wrapping frame counter: frame-start strobe, registered frame_tick and the
// compare against the start of the slot a channel is waiting for.
module servo_frame_timer #(
   parameter int unsigned NCH        = 4,
   parameter int unsigned CLK_PER_US = servo_pkg::CLK_PER_US,
   parameter int unsigned FRAME_US   = servo_pkg::FRAME_US,
   parameter int unsigned SLOT_US    = servo_pkg::SLOT_US,
   localparam int unsigned SW        = $clog2(NCH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [SW-1:0] slot_idx,
   output logic          fs_c,
   output logic          slot_hit_c,
   output logic          frame_tick
);

   localparam int unsigned FRAME_CYC = FRAME_US * CLK_PER_US;
   localparam int unsigned SLOT_CYC  = SLOT_US * CLK_PER_US;
   localparam int unsigned FW        = $clog2(FRAME_CYC);

   logic [FW-1:0] fcnt_q;
   logic [31:0]   slot_start_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         fcnt_q     <= '0;
         frame_tick <= 1'b0;
      end else begin
         fcnt_q     <= (32'(fcnt_q) == FRAME_CYC - 1) ? '0 : fcnt_q + FW'(1);
         frame_tick <= fs_c;
      end
   end

   // A slot boundary that lands exactly on the frame end coincides with the next frame start.
   always_comb begin
      slot_start_c = 32'(slot_idx) * SLOT_CYC;
      if (slot_start_c >= FRAME_CYC) begin
         slot_start_c = '0;
      end
   end

   assign fs_c       = (fcnt_q == '0);
   assign slot_hit_c = (32'(fcnt_q) == slot_start_c);

endmodule

// File: rtl/servo_frame_scheduler.sv
// Time-multiplexes one pulse-width down-counter across NCH servo channels inside a
// fixed frame, with double-buffered, clamped width commands applied at frame start.
module servo_frame_scheduler #(
   parameter int unsigned NCH        = 4,
   parameter int unsigned CLK_PER_US = servo_pkg::CLK_PER_US,
   parameter int unsigned FRAME_US   = servo_pkg::FRAME_US,
   parameter int unsigned SLOT_US    = servo_pkg::SLOT_US,
   parameter int unsigned MIN_US     = servo_pkg::MIN_US,
   parameter int unsigned MAX_US     = servo_pkg::MAX_US,
   parameter int unsigned DEF_US     = servo_pkg::DEF_US,
   localparam int unsigned CHW       = $clog2(NCH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [CHW-1:0] cmd_ch,
   input  logic [11:0]    cmd_us,
   input  logic [NCH-1:0] ch_en,
   output logic [NCH-1:0] servo_out,
   output logic           frame_tick,
   output logic           busy
);

   import servo_pkg::servo_state_t;
   import servo_pkg::S_IDLE;
   import servo_pkg::S_LOAD;
   import servo_pkg::S_PULSE;
   import servo_pkg::S_REST;
   import servo_pkg::US_W;
   import servo_pkg::clamp_us;

   localparam int unsigned    SW         = $clog2(NCH + 1);
   localparam int unsigned    CW         = $clog2(MAX_US * CLK_PER_US + 1);
   localparam bit             FULL_FRAME = (NCH * SLOT_US == FRAME_US);
   localparam logic [CHW-1:0] LAST_CH    = CHW'(NCH - 1);

   logic [US_W-1:0] shadow_q [NCH];
   logic [US_W-1:0] active_q [NCH];
   logic [NCH-1:0]  mask_q;

   servo_state_t    state_q, state_d;
   logic [CHW-1:0]  ch_q, ch_d, nxt_ch_c, ld_ch_c;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NCH-1:0]  out_d;
   logic            slot_hit_q;
   logic            fs_c, slot_hit_c, ld_c, adv_c;
   logic [SW-1:0]   slot_idx_c;

   assign slot_idx_c = SW'(ch_q) + SW'(1);

   servo_frame_timer #(
      .NCH        (NCH),
      .CLK_PER_US (CLK_PER_US),
      .FRAME_US   (FRAME_US),
      .SLOT_US    (SLOT_US)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .slot_idx   (slot_idx_c),
      .fs_c       (fs_c),
      .slot_hit_c (slot_hit_c),
      .frame_tick (frame_tick)
   );

   // Command shadow registers; copied to the active set only at frame start.
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_ready <= 1'b0;
         mask_q    <= '0;
         for (int i = 0; i < NCH; i++) begin
            shadow_q[i] <= US_W'(DEF_US);
            active_q[i] <= US_W'(DEF_US);
         end
      end else begin
         cmd_ready <= 1'b1;
         if (cmd_valid && cmd_ready && (32'(cmd_ch) < NCH)) begin
            shadow_q[cmd_ch] <= clamp_us(cmd_us, US_W'(MIN_US), US_W'(MAX_US));
         end
         if (fs_c) begin
            for (int i = 0; i < NCH; i++) begin
               active_q[i] <= shadow_q[i];
            end
            mask_q <= ch_en;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ch_q       <= '0;
         cnt_q      <= '0;
         servo_out  <= '0;
         busy       <= 1'b0;
         slot_hit_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         cnt_q      <= cnt_d;
         servo_out  <= out_d;
         busy       <= (state_d != S_IDLE);
         slot_hit_q <= slot_hit_c;
      end
   end

   // A pulse as long as the slot ends one cycle past the next boundary, so the
   // next channel's load is folded into that final pulse cycle to keep slot timing.
   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      cnt_d    = cnt_q;
      out_d    = servo_out;
      ld_c     = 1'b0;
      ld_ch_c  = ch_q;
      adv_c    = 1'b0;
      nxt_ch_c = (ch_q == LAST_CH) ? '0 : ch_q + CHW'(1);

      case (state_q)
         S_IDLE: begin
            if (fs_c) begin
               ch_d    = '0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: ld_c = 1'b1;
         S_PULSE: begin
            if (cnt_q == CW'(1)) begin
               out_d = '0;
               if (slot_hit_c) begin
                  adv_c = 1'b1;
               end else if (slot_hit_q) begin
                  if (ch_q == LAST_CH && !FULL_FRAME) begin
                     state_d = S_IDLE;
                  end else begin
                     ch_d    = nxt_ch_c;
                     ld_c    = 1'b1;
                     ld_ch_c = nxt_ch_c;
                  end
               end else begin
                  state_d = S_REST;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_REST: begin
            if (slot_hit_c) begin
               adv_c = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (adv_c) begin
         if (ch_q == LAST_CH && !FULL_FRAME) begin
            state_d = S_IDLE;
         end else begin
            ch_d    = nxt_ch_c;
            state_d = S_LOAD;
         end
      end

      if (ld_c) begin
         cnt_d = CW'(32'(active_q[ld_ch_c]) * CLK_PER_US);
         if (mask_q[ld_ch_c]) begin
            out_d   = NCH'(1) << ld_ch_c;
            state_d = S_PULSE;
         end else begin
            state_d = S_REST;
         end
      end
   end

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Directed bench for servo_frame_scheduler with a scaled-down frame (1 cycle per us).
module tb_servo_frame_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_ch = '0;
   logic [11:0] cmd_us = '0;
   logic [3:0]  ch_en = 4'hF;
   logic [3:0]  servo_out;
   logic        frame_tick;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int off   = 0;
   int multi = 0;
   int rise [4];
   int wid  [4];
   logic [3:0] prev = '0;

   servo_frame_scheduler #(
      .NCH        (4),
      .CLK_PER_US (1),
      .FRAME_US   (2000),
      .SLOT_US    (250),
      .MIN_US     (50),
      .MAX_US     (250),
      .DEF_US     (150)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_ch     (cmd_ch),
      .cmd_us     (cmd_us),
      .ch_en      (ch_en),
      .servo_out  (servo_out),
      .frame_tick (frame_tick),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Pulse monitor: rise offset and width per channel, relative to the frame start.
   always @(negedge clk) begin
      if (frame_tick) begin
         off = 1;
         for (int i = 0; i < 4; i++) begin
            rise[i] = 0;
            wid[i]  = 0;
         end
      end else begin
         off = off + 1;
      end
      for (int i = 0; i < 4; i++) begin
         if (servo_out[i] && !prev[i]) rise[i] = off;
         if (!servo_out[i] && prev[i]) wid[i] = off - rise[i];
      end
      if ($countones(servo_out) > 1) multi = multi + 1;
      prev = servo_out;
   end

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic send_cmd(input int ch, input int us);
      cmd_valid = 1'b1;
      cmd_ch    = 2'(ch);
      cmd_us    = 12'(us);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic frame_start();
      bit seen = 1'b0;
      for (int n = 0; n < 2500 && !seen; n++) begin
         @(posedge clk); #1;
         if (frame_tick) seen = 1'b1;
      end
      check("frame_tick_wait", int'(seen), 1);
   endtask

   task automatic check_frame(input string tag, input int w0, input int w1,
                              input int w2, input int w3);
      int w [4];
      w = '{w0, w1, w2, w3};
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_wid%0d", tag, i), wid[i], w[i]);
         check($sformatf("%s_rise%0d", tag, i), rise[i], (w[i] != 0) ? 2 + 250 * i : 0);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk); #1;
      check("rst_servo", int'(servo_out), 0);
      check("rst_tick", int'(frame_tick), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ready", int'(cmd_ready), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("ready_up", int'(cmd_ready), 1);
      check("first_tick", int'(frame_tick), 1);
      check("busy_load", int'(busy), 1);
      repeat (1100) @(posedge clk); #1;
      check_frame("t1", 150, 150, 150, 150);
      check("busy_idle", int'(busy), 0);

      // mid-frame command waits for the next frame
      frame_start();
      repeat (300) @(posedge clk); #1;
      send_cmd(2, 100);
      repeat (800) @(posedge clk); #1;
      check_frame("t2a", 150, 150, 150, 150);
      frame_start();
      repeat (1100) @(posedge clk); #1;
      check_frame("t2b", 150, 150, 100, 150);

      // clamping, including a full-slot pulse and a zero command
      send_cmd(0, 10);
      frame_start();
      repeat (1100) @(posedge clk); #1;
      check_frame("t3a", 50, 150, 100, 150);
      send_cmd(0, 4000);
      send_cmd(1, 0);
      frame_start();
      repeat (1100) @(posedge clk); #1;
      check_frame("t3b", 250, 50, 100, 150);

      // command accepted in the frame-start cycle itself
      repeat (899) @(posedge clk); #1;
      send_cmd(0, 200);
      check("t4_tick", int'(frame_tick), 1);
      repeat (1100) @(posedge clk); #1;
      check_frame("t4a", 250, 50, 100, 150);
      frame_start();
      repeat (1100) @(posedge clk); #1;
      check_frame("t4b", 200, 50, 100, 150);

      // enable mask changes only at the next frame start
      frame_start();
      repeat (100) @(posedge clk); #1;
      ch_en = 4'b0101;
      repeat (1000) @(posedge clk); #1;
      check_frame("t5a", 200, 50, 100, 150);
      frame_start();
      repeat (1100) @(posedge clk); #1;
      check_frame("t5b", 200, 0, 100, 0);
      ch_en = 4'hF;

      // reset during channel 1's pulse
      frame_start();
      repeat (300) @(posedge clk); #1;
      check("t6_pre", int'(servo_out), 2);
      rst = 1'b1;
      @(posedge clk); #1;
      check("t6_servo", int'(servo_out), 0);
      check("t6_busy", int'(busy), 0);
      repeat (2) @(posedge clk); #1;
      check("t6_ready", int'(cmd_ready), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("t6_tick", int'(frame_tick), 1);
      repeat (1100) @(posedge clk); #1;
      check_frame("t6", 150, 150, 150, 150);
      check("onehot", multi, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
